// File: rtl/gpu_pixel_pkg.sv
// Shared types and helpers for the pixel back end.
// Provides default channel geometry and the inverse-alpha helper.
package gpu_pixel_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 3;
    localparam int CH_W         = DEF_WIDTH;

    typedef logic [CH_W-1:0] channel_t;
    typedef channel_t [DEF_CHANNELS-1:0] pixel_t;

    // (2^w - 1) - a; a is assumed to fit in w bits.
    function automatic logic [31:0] inv_alpha(
        input logic [31:0] a,
        input int          w
    );
        return ((32'd1 << w) - 32'd1) - a;
    endfunction

endpackage

// File: rtl/blend_div255.sv
// Combinational round-half-up divide by 2^W-1, no divider.
// Ports: sum (2W+1 bits, <= (2^W-1)^2) in, q (W bits) out.
module blend_div255
    import gpu_pixel_pkg::*;
#(
    parameter int WIDTH = CH_W
) (
    input  logic [2*WIDTH:0]  sum,
    output logic [WIDTH-1:0]  q
);

    localparam int SW = 2 * WIDTH + 1;

    logic [SW-1:0] t;
    logic [SW-1:0] u;

    // Adding t>>W approximates multiplying by 2^W/(2^W-1);
    // exact for the full product range once the half-LSB bias is in.
    assign t = sum + SW'(1 << (WIDTH - 1));
    assign u = t + (t >> WIDTH);
    assign q = WIDTH'(u >> WIDTH);

endmodule

// File: rtl/alpha_blend_pipe.sv
// Three-stage per-channel alpha blender with valid/ready on both sides.
// Ports: clk, reset_n, in_valid/in_ready, src_color, dst_color, alpha,
//        out_valid/out_ready, out_color (channel 0 in the LSBs).
module alpha_blend_pipe
    import gpu_pixel_pkg::*;
#(
    parameter int WIDTH    = CH_W,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*WIDTH-1:0]   src_color,
    input  logic [CHANNELS*WIDTH-1:0]   dst_color,
    input  logic [WIDTH-1:0]            alpha,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHANNELS*WIDTH-1:0]   out_color
);

    localparam int PW = CHANNELS * WIDTH;
    localparam int MW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 1;

    logic adv;

    logic             s1_valid;
    logic [PW-1:0]    s1_src;
    logic [PW-1:0]    s1_dst;
    logic [WIDTH-1:0] s1_alpha;
    logic [WIDTH-1:0] s1_inv;
    logic [WIDTH-1:0] inv_d;

    logic             s2_valid;
    logic [SW-1:0]    s2_sum [CHANNELS];
    logic [SW-1:0]    sum_d  [CHANNELS];

    logic [PW-1:0]    q_d;

    // Whole pipe moves as one; a held output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign inv_d = WIDTH'(inv_alpha(32'(alpha), WIDTH));

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [MW-1:0] p_src;
        logic [MW-1:0] p_dst;

        assign p_src = MW'(s1_src[ch*WIDTH +: WIDTH]) * MW'(s1_alpha);
        assign p_dst = MW'(s1_dst[ch*WIDTH +: WIDTH]) * MW'(s1_inv);
        assign sum_d[ch] = SW'(p_src) + SW'(p_dst);

        blend_div255 #(.WIDTH(WIDTH)) u_div (
            .sum (s2_sum[ch]),
            .q   (q_d[ch*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_src    <= '0;
            s1_dst    <= '0;
            s1_alpha  <= '0;
            s1_inv    <= '0;
            s2_valid  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                s2_sum[i] <= '0;
            end
            out_valid <= 1'b0;
            out_color <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_src    <= src_color;
            s1_dst    <= dst_color;
            s1_alpha  <= alpha;
            s1_inv    <= inv_d;
            s2_valid  <= s1_valid;
            for (int i = 0; i < CHANNELS; i++) begin
                s2_sum[i] <= sum_d[i];
            end
            out_valid <= s2_valid;
            out_color <= q_d;
        end
    end

endmodule
